// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared word and RAM handshake types
package cpu_types_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {
        FREE   = 2'b00,
        BUSY   = 2'b01,
        ACCESS = 2'b10,
        ERROR  = 2'b11
    } ramstate_t;
endpackage

// File: rtl/coherent_memory_arbiter.sv
// rtl/coherent_memory_arbiter.sv - N-core round-robin RAM arbiter with snooping and cache-to-cache supply
module coherent_memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int CPUS  = 4,
    parameter int WORDS = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [CPUS-1:0]      iREN,
    input  logic [CPUS-1:0]      dREN,
    input  logic [CPUS-1:0]      dWEN,
    input  logic [32*CPUS-1:0]   iaddr,
    input  logic [32*CPUS-1:0]   daddr,
    input  logic [32*CPUS-1:0]   dstore,
    output logic [CPUS-1:0]      iwait,
    output logic [CPUS-1:0]      dwait,
    output logic [32*CPUS-1:0]   iload,
    output logic [32*CPUS-1:0]   dload,
    input  logic [CPUS-1:0]      cctrans,
    input  logic [CPUS-1:0]      ccwrite,
    output logic [CPUS-1:0]      ccwait,
    output logic [CPUS-1:0]      ccinv,
    output logic [32*CPUS-1:0]   ccsnoopaddr,
    output logic                 ramREN,
    output logic                 ramWEN,
    output word_t                ramaddr,
    output word_t                ramstore,
    input  word_t                ramload,
    input  ramstate_t            ramstate
);
    localparam int GW = (CPUS > 1) ? $clog2(CPUS) : 1;
    localparam int WW = $clog2(WORDS + 1);

    typedef enum logic [2:0] {IDLE, IFETCH, WB, SNOOP, RAMRD, C2C} state_t;

    state_t          r_state, w_state_n;
    logic [GW-1:0]   r_gnt, w_gnt_n, r_resp, w_resp_n;
    logic [WW-1:0]   r_wcnt, w_wcnt_n;
    logic [GW-1:0]   r_rr_i, w_rr_i_n, r_rr_wb, w_rr_wb_n, r_rr_cc, w_rr_cc_n;
    logic            w_beat, w_last, w_resp_found;
    logic [GW-1:0]   w_resp_idx;
    logic [31:0]     w_gaddr;

    // First requester at or after ptr, wrapping modulo CPUS.
    function automatic logic [GW-1:0] rr_pick(input logic [CPUS-1:0] req, input logic [GW-1:0] ptr);
        logic [GW-1:0] pick;
        int            idx;
        pick = '0;
        for (int k = CPUS - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % CPUS;
            if (req[idx]) pick = GW'(idx);
        end
        return pick;
    endfunction

    function automatic logic [GW-1:0] rr_next(input logic [GW-1:0] g);
        return (g == GW'(CPUS - 1)) ? '0 : g + 1'b1;
    endfunction

    assign w_beat  = (ramstate == ACCESS);
    assign w_last  = (r_wcnt == WW'(WORDS - 1));
    assign w_gaddr = daddr[32*r_gnt +: 32];

    always_comb begin
        w_resp_found = 1'b0;
        w_resp_idx   = '0;
        for (int j = CPUS - 1; j >= 0; j--) begin
            if (j != int'(r_gnt) && cctrans[j]) begin
                w_resp_found = 1'b1;
                w_resp_idx   = GW'(j);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_resp  <= '0;
            r_wcnt  <= '0;
            r_rr_i  <= '0;
            r_rr_wb <= '0;
            r_rr_cc <= '0;
        end else begin
            r_state <= w_state_n;
            r_gnt   <= w_gnt_n;
            r_resp  <= w_resp_n;
            r_wcnt  <= w_wcnt_n;
            r_rr_i  <= w_rr_i_n;
            r_rr_wb <= w_rr_wb_n;
            r_rr_cc <= w_rr_cc_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_gnt_n   = r_gnt;
        w_resp_n  = r_resp;
        w_wcnt_n  = r_wcnt;
        w_rr_i_n  = r_rr_i;
        w_rr_wb_n = r_rr_wb;
        w_rr_cc_n = r_rr_cc;
        case (r_state)
            IDLE: begin
                w_wcnt_n = '0;
                if (|dWEN) begin
                    w_state_n = WB;
                    w_gnt_n   = rr_pick(dWEN, r_rr_wb);
                end else if (|(cctrans & dREN)) begin
                    w_state_n = SNOOP;
                    w_gnt_n   = rr_pick(cctrans & dREN, r_rr_cc);
                end else if (|iREN) begin
                    w_state_n = IFETCH;
                    w_gnt_n   = rr_pick(iREN, r_rr_i);
                end
            end
            IFETCH: begin
                if (!iREN[r_gnt] || w_beat) begin
                    w_state_n = IDLE;
                    w_rr_i_n  = rr_next(r_gnt);
                end
            end
            WB: begin
                if (!dWEN[r_gnt] || (w_beat && w_last)) begin
                    w_state_n = IDLE;
                    w_rr_wb_n = rr_next(r_gnt);
                end else if (w_beat) begin
                    w_wcnt_n = r_wcnt + 1'b1;
                end
            end
            SNOOP: begin
                w_resp_n  = w_resp_idx;
                w_state_n = w_resp_found ? C2C : RAMRD;
            end
            RAMRD, C2C: begin
                if (!dREN[r_gnt] || (w_beat && w_last)) begin
                    w_state_n = IDLE;
                    w_rr_cc_n = rr_next(r_gnt);
                end else if (w_beat) begin
                    w_wcnt_n = r_wcnt + 1'b1;
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

    // Strobes are gated by the granted request so a withdrawn request never sees another beat.
    always_comb begin
        iwait       = '1;
        dwait       = '1;
        iload       = '0;
        dload       = '0;
        ccwait      = '0;
        ccinv       = '0;
        ccsnoopaddr = '0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        if (r_state == SNOOP || r_state == RAMRD || r_state == C2C) begin
            for (int j = 0; j < CPUS; j++) begin
                if (j != int'(r_gnt)) begin
                    ccwait[j] = 1'b1;
                    ccinv[j]  = ccwrite[r_gnt];
                    if (r_state != C2C) ccsnoopaddr[32*j +: 32] = w_gaddr;
                end
            end
        end
        case (r_state)
            IFETCH: begin
                if (iREN[r_gnt]) begin
                    ramREN                = 1'b1;
                    ramaddr               = iaddr[32*r_gnt +: 32];
                    iload[32*r_gnt +: 32] = ramload;
                    iwait[r_gnt]          = !w_beat;
                end
            end
            WB: begin
                if (dWEN[r_gnt]) begin
                    ramWEN       = 1'b1;
                    ramaddr      = w_gaddr;
                    ramstore     = dstore[32*r_gnt +: 32];
                    dwait[r_gnt] = !w_beat;
                end
            end
            RAMRD: begin
                if (dREN[r_gnt]) begin
                    ramREN                = 1'b1;
                    ramaddr               = w_gaddr;
                    dload[32*r_gnt +: 32] = ramload;
                    dwait[r_gnt]          = !w_beat;
                end
            end
            C2C: begin
                ccsnoopaddr[32*r_resp +: 32] = w_gaddr;
                if (dREN[r_gnt]) begin
                    ramWEN                = 1'b1;
                    ramaddr               = daddr[32*r_resp +: 32];
                    ramstore              = dstore[32*r_resp +: 32];
                    dload[32*r_gnt +: 32] = dstore[32*r_resp +: 32];
                    dwait[r_gnt]          = !w_beat;
                    dwait[r_resp]         = !w_beat;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_coherent_memory_arbiter.sv
// tb/tb_coherent_memory_arbiter.sv - randomized self-checking bench for coherent_memory_arbiter
module tb_coherent_memory_arbiter;
    import cpu_types_pkg::*;

    localparam int CPUS  = 4;
    localparam int WORDS = 2;

    logic                CLK = 1'b0;
    logic                RST;
    logic [CPUS-1:0]     iREN, dREN, dWEN, cctrans, ccwrite;
    logic [32*CPUS-1:0]  iaddr, daddr, dstore;
    logic [CPUS-1:0]     iwait, dwait, ccwait, ccinv;
    logic [32*CPUS-1:0]  iload, dload, ccsnoopaddr;
    logic                ramREN, ramWEN;
    word_t               ramaddr, ramstore, ramload;
    ramstate_t           ramstate;

    coherent_memory_arbiter #(.CPUS(CPUS), .WORDS(WORDS)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
        .iaddr(iaddr), .daddr(daddr), .dstore(dstore),
        .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
        .cctrans(cctrans), .ccwrite(ccwrite), .ccwait(ccwait), .ccinv(ccinv),
        .ccsnoopaddr(ccsnoopaddr),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    // RAM environment: mem is what the DUT actually writes, ref_mem is the expected image.
    word_t mem     [256];
    word_t ref_mem [256];
    word_t wb_data [WORDS];
    word_t sup_data[WORDS];
    int    rs_mode = 0;
    int    bcnt    = 0;
    int    rnd     = 3;
    int    n_checks = 0;
    int    n_errors = 0;

    assign ramload = mem[ramaddr[9:2]];

    always_comb begin
        ramstate = ACCESS;
        if (rs_mode == 1) begin
            case (rnd)
                0:       ramstate = BUSY;
                1:       ramstate = ERROR;
                2:       ramstate = FREE;
                default: ramstate = ACCESS;
            endcase
        end else if (rs_mode == 2) begin
            ramstate = (bcnt == 2) ? ACCESS : BUSY;
        end
    end

    always @(posedge CLK) begin
        rnd <= $urandom_range(0, 5);
        if ((ramREN || ramWEN) && ramstate != ACCESS) bcnt <= bcnt + 1;
        else bcnt <= 0;
    end

    always @(negedge CLK) begin
        if (ramWEN === 1'b1 && ramstate == ACCESS) mem[ramaddr[9:2]] = ramstore;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        iREN = '0; dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0;
        iaddr = '0; daddr = '0; dstore = '0;
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_iwait"}, iwait, {CPUS{1'b1}});
        check_eq({tag, "_dwait"}, dwait, {CPUS{1'b1}});
        check_eq({tag, "_ccwait"}, ccwait, '0);
        check_eq({tag, "_ccinv"}, ccinv, '0);
        check_eq({tag, "_strobes"}, {ramREN, ramWEN}, '0);
    endtask

    // kind 0: instruction fetch, 1: writeback, 2: coherent read (sup < 0 means no Modified hit)
    task automatic do_txn(input int kind, input int c, input int sup, input bit wr, input logic [31:0] base);
        int              beats, need, lat, idx;
        bit              snooped, hit;
        logic [31:0]     exp;
        logic [CPUS-1:0] m;
        need = (kind == 0) ? 1 : WORDS;
        beats = 0; lat = 0; snooped = 0;
        idx = int'(base[9:2]);
        m = '1; m[c] = 1'b0;
        case (kind)
            0: begin iaddr[32*c +: 32] = base; iREN[c] = 1'b1; end
            1: begin daddr[32*c +: 32] = base; dstore[32*c +: 32] = wb_data[0]; dWEN[c] = 1'b1; end
            default: begin
                daddr[32*c +: 32] = base; dREN[c] = 1'b1; cctrans[c] = 1'b1; ccwrite[c] = wr;
                if (sup >= 0) begin
                    cctrans[sup] = 1'b1;
                    daddr[32*sup +: 32] = base;
                    dstore[32*sup +: 32] = sup_data[0];
                end
            end
        endcase
        for (int cyc = 1; cyc <= 60 && beats < need; cyc++) begin
            @(negedge CLK);
            hit = 1'b0;
            if (kind == 2 && !snooped && ccwait != '0) begin
                snooped = 1'b1;
                check_eq("snoop_ccwait", ccwait, m);
                check_eq("snoop_ccinv", ccinv, {CPUS{wr}} & m);
                check_eq("snoop_ram_idle", {ramREN, ramWEN}, '0);
                for (int j = 0; j < CPUS; j++)
                    if (j != c) check_eq("snoop_addr", ccsnoopaddr[32*j +: 32], base);
            end
            if (kind == 0 && !iwait[c]) begin
                check_eq("if_data", iload[32*c +: 32], ref_mem[idx]);
                hit = 1'b1;
            end
            if (kind == 1 && !dwait[c]) begin
                check_eq("wb_addr", ramaddr, base + 32'(4 * beats));
                check_eq("wb_store", ramstore, wb_data[beats]);
                ref_mem[idx + beats] = wb_data[beats];
                hit = 1'b1;
            end
            if (kind == 2 && !dwait[c]) begin
                check_eq("rd_ccinv", ccinv, {CPUS{wr}} & m);
                if (sup >= 0) begin
                    exp = sup_data[beats];
                    check_eq("c2c_sup_dwait", dwait[sup], 1'b0);
                    check_eq("c2c_ram_addr", ramaddr, base + 32'(4 * beats));
                    check_eq("c2c_ram_wen", ramWEN, 1'b1);
                    check_eq("c2c_snoopaddr", ccsnoopaddr[32*sup +: 32], base + 32'(4 * beats));
                    ref_mem[idx + beats] = exp;
                end else begin
                    exp = ref_mem[idx + beats];
                    check_eq("rd_ccwait", ccwait, m);
                end
                check_eq("rd_data", dload[32*c +: 32], exp);
                hit = 1'b1;
            end
            if (hit) begin
                if (beats == 0) lat = cyc;
                beats++;
            end
            @(posedge CLK); #1;
            if (hit && beats < need) begin
                daddr[32*c +: 32] = daddr[32*c +: 32] + 32'd4;
                if (kind == 1) dstore[32*c +: 32] = wb_data[beats];
                if (kind == 2 && sup >= 0) begin
                    daddr[32*sup +: 32] = daddr[32*sup +: 32] + 32'd4;
                    dstore[32*sup +: 32] = sup_data[beats];
                end
            end
        end
        check_eq("beats_done", beats, need);
        if (rs_mode == 0) check_eq("first_latency", lat, (kind == 2) ? 3 : 2);
        clear_inputs();
        @(negedge CLK);
        check_idle("post_txn");
        if (kind == 1 || (kind == 2 && sup >= 0))
            for (int w = 0; w < WORDS; w++) check_eq("ram_image", mem[idx + w], ref_mem[idx + w]);
        @(posedge CLK); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int seen, last, own, ev;
        int expc[3];
        bit adv, dropw, dropi;

        RST = 1'b1;
        clear_inputs();
        for (int i = 0; i < 256; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end

        // Reset with every request high; RAM BUSY keeps the first WB beat from landing.
        rs_mode = 2;
        iREN = '1; dREN = '1; dWEN = '1; cctrans = '1;
        daddr[31:0] = 32'h40;
        repeat (2) begin
            @(negedge CLK);
            check_idle("reset");
        end
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        check_idle("reset_release");
        @(negedge CLK);
        check_eq("first_grant_wb_wen", ramWEN, 1'b1);
        check_eq("first_grant_wb_addr", ramaddr, 32'h40);
        check_eq("first_grant_wb_busy", dwait, {CPUS{1'b1}});
        @(posedge CLK); #1;
        RST = 1'b1;
        clear_inputs();
        @(posedge CLK); #1;
        RST = 1'b0;

        // Instruction round-robin with all iREN held.
        rs_mode = 0;
        for (int c = 0; c < CPUS; c++) iaddr[32*c +: 32] = 32'h200 + 32'(16 * c);
        iREN = '1;
        seen = 0; last = 0;
        for (int cyc = 1; cyc <= 30 && seen < 5; cyc++) begin
            @(negedge CLK);
            if (iwait != '1) begin
                own = 0;
                for (int c = CPUS - 1; c >= 0; c--) if (!iwait[c]) own = c;
                check_eq("rr_single", $countones(~iwait), 1);
                check_eq("rr_order", own, seen % CPUS);
                check_eq("rr_iload", iload[32*own +: 32], ref_mem[(32'h200 + 16 * own) >> 2]);
                check_eq("rr_spacing", cyc - last, 2);
                last = cyc;
                seen++;
            end
        end
        check_eq("rr_count", seen, 5);
        @(posedge CLK); #1;
        clear_inputs();
        @(posedge CLK); #1;

        // Clean coherent read by CPU2.
        do_txn(2, 2, -1, 1'b0, 32'h100);

        // CPU1 BusRdX, CPU3 supplies Modified data.
        sup_data[0] = 32'hDEADBEEF;
        sup_data[1] = 32'hCAFEF00D;
        do_txn(2, 1, 3, 1'b1, 32'h180);

        // Writeback beats IFETCH raised together; 2 BUSY cycles before every beat.
        rs_mode = 2;
        wb_data[0] = $urandom; wb_data[1] = $urandom;
        daddr[31:0] = 32'h300; dstore[31:0] = wb_data[0]; iaddr[63:32] = 32'h340;
        dWEN[0] = 1'b1; iREN[1] = 1'b1;
        expc[0] = 4; expc[1] = 7; expc[2] = 11;
        ev = 0;
        for (int cyc = 1; cyc <= 30 && ev < 3; cyc++) begin
            @(negedge CLK);
            adv = 1'b0; dropw = 1'b0; dropi = 1'b0;
            if (!dwait[0]) begin
                check_eq("prio_wb_cycle", cyc, expc[ev]);
                check_eq("prio_wb_store", ramstore, wb_data[ev % WORDS]);
                ref_mem[(32'h300 >> 2) + (ev % WORDS)] = wb_data[ev % WORDS];
                ev++;
                if (ev == WORDS) dropw = 1'b1; else adv = 1'b1;
            end else if (!iwait[1]) begin
                check_eq("prio_if_cycle", cyc, expc[ev]);
                check_eq("prio_if_after_wb", ev, 2);
                check_eq("prio_if_data", iload[63:32], ref_mem[32'h340 >> 2]);
                ev++;
                dropi = 1'b1;
            end
            @(posedge CLK); #1;
            if (adv) begin daddr[31:0] = 32'h304; dstore[31:0] = wb_data[1]; end
            if (dropw) dWEN[0] = 1'b0;
            if (dropi) iREN[1] = 1'b0;
        end
        check_eq("prio_events", ev, 3);
        clear_inputs();
        @(negedge CLK);
        for (int w = 0; w < WORDS; w++) check_eq("prio_ram_image", mem[(32'h300 >> 2) + w], ref_mem[(32'h300 >> 2) + w]);
        @(posedge CLK); #1;

        // dREN withdrawn after the first RAMRD beat.
        rs_mode = 0;
        daddr[95:64] = 32'h140; dREN[2] = 1'b1; cctrans[2] = 1'b1;
        repeat (3) @(negedge CLK);
        check_eq("abort_beat0", dwait[2], 1'b0);
        check_eq("abort_beat0_data", dload[95:64], ref_mem[32'h140 >> 2]);
        @(posedge CLK); #1;
        daddr[95:64] = 32'h144; dREN[2] = 1'b0; cctrans[2] = 1'b0;
        @(negedge CLK);
        check_eq("abort_no_strobe", ramREN, 1'b0);
        check_eq("abort_no_beat", dwait[2], 1'b1);
        @(negedge CLK);
        check_idle("abort_idle");
        @(posedge CLK); #1;

        // Reset asserted in the middle of a C2C transfer.
        daddr[63:32] = 32'h1c0; daddr[127:96] = 32'h1c0; dstore[127:96] = 32'h12345678;
        dREN[1] = 1'b1; cctrans[1] = 1'b1; ccwrite[1] = 1'b1; cctrans[3] = 1'b1;
        repeat (3) @(negedge CLK);
        check_eq("c2c_active", ramWEN, 1'b1);
        @(posedge CLK); #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        check_idle("reset_mid_c2c");
        clear_inputs();
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];

        // Randomized single-requester transactions.
        for (int it = 0; it < 24; it++) begin
            int kind, c, sup;
            bit wr;
            kind = $urandom_range(0, 2);
            c = $urandom_range(0, CPUS - 1);
            sup = -1;
            if (kind == 2 && $urandom_range(0, 1) == 1) sup = (c + $urandom_range(1, CPUS - 1)) % CPUS;
            wr = 1'($urandom_range(0, 1));
            rs_mode = $urandom_range(0, 1);
            for (int w = 0; w < WORDS; w++) begin
                wb_data[w] = $urandom;
                sup_data[w] = $urandom;
            end
            do_txn(kind, c, sup, wr, 32'($urandom_range(0, 127) * 8));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
